axi4_lite_rif_bridge: RTL and testbench

AXI4-Lite slave that bridges onto NUM_RIF independent register-interface (RIF) targets, selected by an address-region decode. Each RIF access is multi-cycle: the request is held until the target acknowledges. Read and write paths run as separate state machines, so one read and one write can be in flight at once. Out-of-range addresses get DECERR, and accesses that are never acknowledged get SLVERR after a timeout. It sits between the AXI interconnect and a group of peripheral register files.

---
 rtl/axi4_lite_rif_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_rif_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_rif_bridge.sv
// AXI4-Lite slave bridging to NUM_RIF register-interface targets, with independent read/write FSMs.
// Optional ack timeout (SLVERR) is compiled in with `define AXI4_LITE_RIF_TIMEOUT_EN.
module axi4_lite_rif_bridge #(
  parameter int AXI_ID_WIDTH   = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int REGION_BITS    = 10,
  parameter int NUM_RIF        = 4,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [AXI_ID_WIDTH-1:0]            awid,
  input  logic [AXI_ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                         awprot,
  input  logic                               awvalid,
  output logic                               awready,
  input  logic [AXI_DATA_WIDTH-1:0]          wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]        wstrb,
  input  logic                               wvalid,
  output logic                               wready,
  output logic [AXI_ID_WIDTH-1:0]            bid,
  output logic [1:0]                         bresp,
  output logic                               bvalid,
  input  logic                               bready,
  input  logic [AXI_ID_WIDTH-1:0]            arid,
  input  logic [AXI_ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                         arprot,
  input  logic                               arvalid,
  output logic                               arready,
  output logic [AXI_ID_WIDTH-1:0]            rid,
  output logic [AXI_DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                         rresp,
  output logic                               rvalid,
  input  logic                               rready,
  output logic [REGION_BITS-1:0]             rif_waddr,
  output logic [AXI_DATA_WIDTH-1:0]          rif_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]        rif_wstrb,
  output logic [NUM_RIF-1:0]                 rif_wr_req,
  input  logic [NUM_RIF-1:0]                 rif_wack,
  output logic [REGION_BITS-1:0]             rif_raddr,
  output logic [NUM_RIF-1:0]                 rif_rd_req,
  input  logic [NUM_RIF-1:0]                 rif_rack,
  input  logic [NUM_RIF*AXI_DATA_WIDTH-1:0]  rif_rdata
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_RIF > 1) ? $clog2(NUM_RIF) : 1;
  localparam logic [AXI_ADDR_WIDTH-1:0] NUM_RIF_A = AXI_ADDR_WIDTH'(NUM_RIF);
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  if ((AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64) || NUM_RIF < 1 || NUM_RIF > 16 ||
      AXI_ADDR_WIDTH < REGION_BITS + $clog2(NUM_RIF) || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("axi4_lite_rif_bridge: illegal parameter set");
  end

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_ACCESS = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACCESS = 2'd1, R_RESP = 2'd2} rstate_t;

  function automatic logic [NUM_RIF-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_RIF-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_RIF; i++) res[i] = (idx == IDX_W'(i));
    return res;
  endfunction

  // AND-OR mux keyed by the one-hot request, so no separate index register is needed
  function automatic logic [AXI_DATA_WIDTH-1:0] rd_slice(input logic [NUM_RIF*AXI_DATA_WIDTH-1:0] bus,
                                                         input logic [NUM_RIF-1:0] sel);
    logic [AXI_DATA_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < NUM_RIF; i++) res = res | (bus[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] & {AXI_DATA_WIDTH{sel[i]}});
    return res;
  endfunction

  logic unused_prot_s;
  assign unused_prot_s = ^{awprot, arprot};

  wstate_t wstate_r, wstate_n;
  rstate_t rstate_r, rstate_n;
  logic aw_done_r, aw_done_n, w_done_r, w_done_n;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_r, awaddr_n;
  logic awready_r, awready_n, wready_r, wready_n, bvalid_r, bvalid_n;
  logic [1:0] bresp_r, bresp_n, rresp_r, rresp_n;
  logic [AXI_ID_WIDTH-1:0] bid_r, bid_n, rid_r, rid_n;
  logic [NUM_RIF-1:0] wr_req_r, wr_req_n, rd_req_r, rd_req_n;
  logic [REGION_BITS-1:0] waddr_r, waddr_n, raddr_r, raddr_n;
  logic [AXI_DATA_WIDTH-1:0] wdata_r, wdata_n, rdata_r, rdata_n;
  logic [STRB_W-1:0] wstrb_r, wstrb_n;
  logic arready_r, arready_n, rvalid_r, rvalid_n;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
  logic [CNT_W-1:0] wcnt_r, wcnt_n, rcnt_r, rcnt_n;
`endif

  logic aw_hs_s, w_hs_s, ar_hs_s, aw_have_s, w_have_s;
  logic [AXI_ADDR_WIDTH-1:0] aw_cur_s, aw_idx_full_s, ar_idx_full_s;

  assign aw_hs_s       = awvalid & awready_r;
  assign w_hs_s        = wvalid & wready_r;
  assign ar_hs_s       = arvalid & arready_r;
  assign aw_have_s     = aw_done_r | aw_hs_s;
  assign w_have_s      = w_done_r | w_hs_s;
  assign aw_cur_s      = aw_hs_s ? awaddr : awaddr_r;
  assign aw_idx_full_s = aw_cur_s >> REGION_BITS;
  assign ar_idx_full_s = araddr >> REGION_BITS;

  // Write FSM next-state and next-output logic
  always_comb begin
    wstate_n  = wstate_r;
    aw_done_n = aw_done_r;
    w_done_n  = w_done_r;
    awready_n = awready_r;
    wready_n  = wready_r;
    bvalid_n  = bvalid_r;
    bresp_n   = bresp_r;
    wr_req_n  = wr_req_r;
    waddr_n   = waddr_r;
    awaddr_n  = aw_cur_s;
    bid_n     = aw_hs_s ? awid : bid_r;
    wdata_n   = w_hs_s ? wdata : wdata_r;
    wstrb_n   = w_hs_s ? wstrb : wstrb_r;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
    wcnt_n    = wcnt_r;
`endif
    case (wstate_r)
      W_IDLE: begin
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
        wcnt_n = '0;
`endif
        if (aw_have_s && w_have_s) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          awready_n = 1'b0;
          wready_n  = 1'b0;
          if (aw_idx_full_s >= NUM_RIF_A) begin
            wstate_n = W_RESP;
            bvalid_n = 1'b1;
            bresp_n  = 2'b11;
          end else begin
            wstate_n = W_ACCESS;
            wr_req_n = onehot(aw_idx_full_s[IDX_W-1:0]);
            waddr_n  = aw_cur_s[REGION_BITS-1:0];
          end
        end else begin
          aw_done_n = aw_have_s;
          w_done_n  = w_have_s;
          awready_n = ~aw_have_s;
          wready_n  = ~w_have_s;
        end
      end
      W_ACCESS: begin
        if (|(rif_wack & wr_req_r)) begin
          wr_req_n = '0;
          wstate_n = W_RESP;
          bvalid_n = 1'b1;
          bresp_n  = 2'b00;
        end else begin
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
          if (wcnt_r == CNT_LAST) begin
            wr_req_n = '0;
            wstate_n = W_RESP;
            bvalid_n = 1'b1;
            bresp_n  = 2'b10;
          end else begin
            wcnt_n = wcnt_r + 1'b1;
          end
`else
          wstate_n = W_ACCESS;
`endif
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_n  = 1'b0;
          wstate_n  = W_IDLE;
          awready_n = 1'b1;
          wready_n  = 1'b1;
        end else begin
          bvalid_n = 1'b1;
        end
      end
      default: wstate_n = W_IDLE;
    endcase
  end

  // Read FSM next-state and next-output logic
  always_comb begin
    rstate_n  = rstate_r;
    arready_n = arready_r;
    rvalid_n  = rvalid_r;
    rresp_n   = rresp_r;
    rdata_n   = rdata_r;
    rid_n     = rid_r;
    rd_req_n  = rd_req_r;
    raddr_n   = raddr_r;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
    rcnt_n    = rcnt_r;
`endif
    case (rstate_r)
      R_IDLE: begin
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
        rcnt_n = '0;
`endif
        if (ar_hs_s) begin
          arready_n = 1'b0;
          rid_n     = arid;
          if (ar_idx_full_s >= NUM_RIF_A) begin
            rstate_n = R_RESP;
            rvalid_n = 1'b1;
            rresp_n  = 2'b11;
            rdata_n  = '0;
          end else begin
            rstate_n = R_ACCESS;
            rd_req_n = onehot(ar_idx_full_s[IDX_W-1:0]);
            raddr_n  = araddr[REGION_BITS-1:0];
          end
        end else begin
          arready_n = 1'b1;
        end
      end
      R_ACCESS: begin
        if (|(rif_rack & rd_req_r)) begin
          rd_req_n = '0;
          rstate_n = R_RESP;
          rvalid_n = 1'b1;
          rresp_n  = 2'b00;
          rdata_n  = rd_slice(rif_rdata, rd_req_r);
        end else begin
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
          if (rcnt_r == CNT_LAST) begin
            rd_req_n = '0;
            rstate_n = R_RESP;
            rvalid_n = 1'b1;
            rresp_n  = 2'b10;
            rdata_n  = '0;
          end else begin
            rcnt_n = rcnt_r + 1'b1;
          end
`else
          rstate_n = R_ACCESS;
`endif
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_n  = 1'b0;
          rstate_n  = R_IDLE;
          arready_n = 1'b1;
        end else begin
          rvalid_n = 1'b1;
        end
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  // State and registered outputs for both FSMs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate_r  <= W_IDLE;
      rstate_r  <= R_IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      awaddr_r  <= '0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= 2'b00;
      bid_r     <= '0;
      wr_req_r  <= '0;
      waddr_r   <= '0;
      wdata_r   <= '0;
      wstrb_r   <= '0;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rresp_r   <= 2'b00;
      rdata_r   <= '0;
      rid_r     <= '0;
      rd_req_r  <= '0;
      raddr_r   <= '0;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
      wcnt_r    <= '0;
      rcnt_r    <= '0;
`endif
    end else begin
      wstate_r  <= wstate_n;
      rstate_r  <= rstate_n;
      aw_done_r <= aw_done_n;
      w_done_r  <= w_done_n;
      awaddr_r  <= awaddr_n;
      awready_r <= awready_n;
      wready_r  <= wready_n;
      bvalid_r  <= bvalid_n;
      bresp_r   <= bresp_n;
      bid_r     <= bid_n;
      wr_req_r  <= wr_req_n;
      waddr_r   <= waddr_n;
      wdata_r   <= wdata_n;
      wstrb_r   <= wstrb_n;
      arready_r <= arready_n;
      rvalid_r  <= rvalid_n;
      rresp_r   <= rresp_n;
      rdata_r   <= rdata_n;
      rid_r     <= rid_n;
      rd_req_r  <= rd_req_n;
      raddr_r   <= raddr_n;
`ifdef AXI4_LITE_RIF_TIMEOUT_EN
      wcnt_r    <= wcnt_n;
      rcnt_r    <= rcnt_n;
`endif
    end
  end

  assign awready    = awready_r;
  assign wready     = wready_r;
  assign bvalid     = bvalid_r;
  assign bresp      = bresp_r;
  assign bid        = bid_r;
  assign rif_wr_req = wr_req_r;
  assign rif_waddr  = waddr_r;
  assign rif_wdata  = wdata_r;
  assign rif_wstrb  = wstrb_r;
  assign arready    = arready_r;
  assign rvalid     = rvalid_r;
  assign rresp      = rresp_r;
  assign rdata      = rdata_r;
  assign rid        = rid_r;
  assign rif_rd_req = rd_req_r;
  assign rif_raddr  = raddr_r;

endmodule

// File: tb/tb_axi4_lite_rif_bridge.sv
// Directed self-checking bench for axi4_lite_rif_bridge (NUM_RIF=4, 32-bit data, TIMEOUT_CYCLES=8).
// Targets are modelled by per-target ack latencies; 0 means the target never acks.
module tb_axi4_lite_rif_bridge;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [0:0]   awid, bid, arid, rid;
  logic [15:0]  awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata, rif_wdata;
  logic [3:0]   wstrb, rif_wstrb;
  logic [1:0]   bresp, rresp;
  logic [9:0]   rif_waddr, rif_raddr;
  logic [3:0]   rif_wr_req, rif_wack, rif_rd_req, rif_rack;
  logic [127:0] rif_rdata;

  int n_vec = 0;
  int n_err = 0;
  int wlat[4] = '{1, 1, 1, 1};
  int rlat[4] = '{1, 1, 1, 1};
  int wcnt[4] = '{0, 0, 0, 0};
  int rcnt[4] = '{0, 0, 0, 0};
  int cyc;

  axi4_lite_rif_bridge #(
    .AXI_ID_WIDTH(1), .AXI_DATA_WIDTH(32), .REGION_BITS(10),
    .NUM_RIF(4), .AXI_ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .rif_waddr(rif_waddr), .rif_wdata(rif_wdata), .rif_wstrb(rif_wstrb),
    .rif_wr_req(rif_wr_req), .rif_wack(rif_wack),
    .rif_raddr(rif_raddr), .rif_rd_req(rif_rd_req), .rif_rack(rif_rack),
    .rif_rdata(rif_rdata)
  );

  always #5 aclk = ~aclk;

  // Target model: ack on the lat-th cycle a request is seen high
  always @(negedge aclk) begin
    for (int i = 0; i < 4; i++) begin
      if (rif_wr_req[i]) begin
        rif_wack[i] = (wcnt[i] + 1 == wlat[i]);
        wcnt[i] = wcnt[i] + 1;
      end else begin
        rif_wack[i] = 1'b0;
        wcnt[i] = 0;
      end
      if (rif_rd_req[i]) begin
        rif_rack[i] = (rcnt[i] + 1 == rlat[i]);
        rcnt[i] = rcnt[i] + 1;
      end else begin
        rif_rack[i] = 1'b0;
        rcnt[i] = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic send_write(input logic id, input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
    awid = id; awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic send_read(input logic id, input logic [15:0] addr);
    arid = id; araddr = addr; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
  endtask

  task automatic wait_bvalid(input string tag, output int req_cyc);
    req_cyc = 0;
    for (int i = 0; i < 64 && !bvalid; i++) begin
      if (|rif_wr_req) req_cyc++;
      tick();
    end
    check({tag, "_bvalid"}, bvalid, 1'b1);
  endtask

  task automatic wait_rvalid(input string tag, output int req_cyc);
    req_cyc = 0;
    for (int i = 0; i < 64 && !rvalid; i++) begin
      if (|rif_rd_req) req_cyc++;
      tick();
    end
    check({tag, "_rvalid"}, rvalid, 1'b1);
  endtask

  initial begin
    aresetn = 1'b0;
    awid = 1'b0; awaddr = 16'h0000; awprot = 3'b000; awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b1;
    arid = 1'b0; araddr = 16'h0000; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
    rif_wack = 4'h0; rif_rack = 4'h0;
    rif_rdata = {32'h12345678, 32'h55AA55AA, 32'h0BADF00D, 32'hCAFEF00D};
    repeat (3) tick();
    check("rst_awready", awready, 1'b0);
    check("rst_wready", wready, 1'b0);
    check("rst_arready", arready, 1'b0);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_reqs", {rif_wr_req, rif_rd_req}, 8'h00);
    check("rst_resp_data", {bresp, rresp, rdata, bid, rid}, 38'h0);
    aresetn = 1'b1;
    tick();
    check("rdy_after_rst", {awready, wready, arready}, 3'b111);

    // AW+W same cycle, target 1 acks on the first request cycle
    send_write(1'b1, 16'h0408, 32'hDEADBEEF, 4'hF);
    check("w1_req", rif_wr_req, 4'b0010);
    check("w1_waddr", rif_waddr, 10'h008);
    check("w1_wdata", rif_wdata, 32'hDEADBEEF);
    check("w1_wstrb", rif_wstrb, 4'hF);
    check("w1_no_b_yet", {bvalid, awready, wready}, 3'b000);
    tick();
    check("w1_bvalid", bvalid, 1'b1);
    check("w1_bresp", bresp, 2'b00);
    check("w1_bid", bid, 1'b1);
    check("w1_req_drop", rif_wr_req, 4'b0000);
    tick();
    check("w1_b_done", bvalid, 1'b0);
    check("w1_rdy_back", {awready, wready}, 2'b11);

    // W three cycles ahead of AW, target 2 acks after 5 request cycles
    wlat[2] = 5;
    wdata = 32'hA5A55A5A; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("w2_wready_drop", wready, 1'b0);
    check("w2_awready_hold", awready, 1'b1);
    tick(); tick();
    awid = 1'b0; awaddr = 16'h0810; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("w2_req", rif_wr_req, 4'b0100);
    check("w2_waddr", rif_waddr, 10'h010);
    wait_bvalid("w2", cyc);
    check("w2_req_cycles", cyc, 5);
    check("w2_bresp", bresp, 2'b00);
    check("w2_bid", bid, 1'b0);
    check("w2_wdata", {rif_wdata, rif_wstrb}, {32'hA5A55A5A, 4'h3});
    tick();

    // Write decode error: no RIF access, DECERR
    send_write(1'b1, 16'hFC00, 32'h11111111, 4'hF);
    check("wde_no_req", rif_wr_req, 4'b0000);
    check("wde_b", {bvalid, bresp, bid}, {1'b1, 2'b11, 1'b1});
    tick();

    // Read decode error at 0x1000
    send_read(1'b1, 16'h1000);
    check("rde_no_req", rif_rd_req, 4'b0000);
    check("rde_r", {rvalid, rresp, rid}, {1'b1, 2'b11, 1'b1});
    check("rde_rdata", rdata, 32'h0);
    tick();
    check("rde_done", {rvalid, arready}, 2'b01);

    // Read target 3 with rready held low for 4 cycles
    rlat[3] = 2; rready = 1'b0;
    send_read(1'b1, 16'h0FFC);
    check("r3_req", rif_rd_req, 4'b1000);
    check("r3_raddr", rif_raddr, 10'h3FC);
    check("r3_arready", arready, 1'b0);
    wait_rvalid("r3", cyc);
    check("r3_req_cycles", cyc, 2);
    check("r3_r", {rresp, rid, rdata}, {2'b00, 1'b1, 32'h12345678});
    for (int k = 0; k < 4; k++) begin
      tick();
      check("r3_hold", {rvalid, arready, rid, rdata}, {1'b1, 1'b0, 1'b1, 32'h12345678});
    end
    rready = 1'b1;
    tick();
    check("r3_done", {rvalid, arready}, 2'b01);

    // Concurrent write (wstrb=0) and read to target 0
    wlat[0] = 3; rlat[0] = 1;
    arid = 1'b0; araddr = 16'h0020; arvalid = 1'b1;
    send_write(1'b0, 16'h0004, 32'h11223344, 4'h0);
    arvalid = 1'b0;
    check("cc_reqs", {rif_wr_req, rif_rd_req}, 8'h11);
    check("cc_addrs", {rif_waddr, rif_raddr}, {10'h004, 10'h020});
    check("cc_wstrb0", rif_wstrb, 4'h0);
    wait_rvalid("cc_rd", cyc);
    check("cc_rdata", {rresp, rdata}, {2'b00, 32'hCAFEF00D});
    wait_bvalid("cc_wr", cyc);
    check("cc_wr_cycles", cyc, 2);
    check("cc_bresp", bresp, 2'b00);
    tick();

    // Reset in the middle of an unacknowledged write
    wlat[2] = 0;
    send_write(1'b1, 16'h0800, 32'h0F0F0F0F, 4'hF);
    tick();
    check("rm_req", rif_wr_req, 4'b0100);
    aresetn = 1'b0;
    tick();
    check("rm_clear", {rif_wr_req, rif_rd_req, bvalid, rvalid, awready, wready, arready}, 13'h0);
    aresetn = 1'b1;
    tick();
    check("rm_rdy", {awready, wready, arready}, 3'b111);
    wlat[2] = 1;
    send_write(1'b0, 16'h0804, 32'h13572468, 4'hC);
    check("rm_w_req", {rif_wr_req, rif_waddr, rif_wdata}, {4'b0100, 10'h004, 32'h13572468});
    wait_bvalid("rm_w", cyc);
    check("rm_w_resp", {cyc[3:0], bresp, bid}, {4'd1, 2'b00, 1'b0});
    tick();

`ifdef AXI4_LITE_RIF_TIMEOUT_EN
    // Timeout: never-acking target, then ack in the last allowed cycle
    rlat[1] = 0;
    send_read(1'b0, 16'h0400);
    wait_rvalid("to_r", cyc);
    check("to_r_cycles", cyc, 8);
    check("to_r_resp", {rresp, rdata}, {2'b10, 32'h0});
    tick();
    rlat[1] = 8;
    send_read(1'b0, 16'h0400);
    wait_rvalid("to_rack", cyc);
    check("to_rack_cycles", cyc, 8);
    check("to_rack_resp", {rresp, rdata}, {2'b00, 32'h0BADF00D});
    tick();
    wlat[3] = 0;
    send_write(1'b1, 16'h0C00, 32'h0, 4'hF);
    wait_bvalid("to_w", cyc);
    check("to_w_cycles", cyc, 8);
    check("to_w_resp", {bresp, bid}, {2'b10, 1'b1});
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
